// File: rtl/cpu_clken_ctrl.sv
// Programmable CPU clock-enable generator.
// Produces a one-cycle cpu_clken every div clk25 cycles while running. While halted it
// produces single-step pulses instead. Divisor and run/halt changes arrive over a
// valid/ready handshake. They are applied only on frame boundaries, so an enable
// period is never cut short.
module cpu_clken_ctrl #(
  parameter int unsigned DIV_W       = 26,
  parameter int unsigned DEFAULT_DIV = 25
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_halt,
  input  logic             step_req,
  output logic             cpu_clken,
  output logic             halted,
  output logic             step_done,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] DefaultDiv = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] OneDiv     = DIV_W'(1);

  typedef enum logic {StRun, StHalt} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_halt_q, pend_halt_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             step_hist_q;
  logic             clken_q, clken_d;
  logic             step_done_q, step_done_d;
  logic             halted_q, halted_d;

  logic             boundary;
  logic             step_edge;
  logic             accept;
  logic             apply;
  logic             step_fire;
  logic [DIV_W-1:0] cfg_div_clamped;

  // In HALT every cycle is a boundary, so pending config lands on the next cycle.
  assign boundary        = (state_q == StHalt) || (cnt_q == div_q - OneDiv);
  assign step_edge       = step_req & ~step_hist_q;
  assign accept          = cfg_valid & cfg_ready_q;
  assign apply           = boundary & pend_q;
  // Divisors 0 and 1 both mean "enable every cycle".
  assign cfg_div_clamped = (cfg_div <= OneDiv) ? OneDiv : cfg_div;

  // State register: all controller state, synchronous reset.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      div_q       <= DefaultDiv;
      pend_q      <= 1'b0;
      pend_div_q  <= DefaultDiv;
      pend_halt_q <= 1'b0;
      cfg_ready_q <= 1'b1;
      step_hist_q <= 1'b0;
      clken_q     <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      pend_halt_q <= pend_halt_d;
      cfg_ready_q <= cfg_ready_d;
      step_hist_q <= step_req;
      clken_q     <= clken_d;
      step_done_q <= step_done_d;
      halted_q    <= halted_d;
    end
  end

  // Next state: frame counter, config apply at boundary, config capture on handshake.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_halt_d = pend_halt_q;
    cfg_ready_d = cfg_ready_q;
    if (state_q == StRun) begin
      cnt_d = boundary ? '0 : cnt_q + OneDiv;
    end else begin
      cnt_d = '0;
    end
    // Apply uses only what was already pending; accept and apply never overlap
    // because accept needs cfg_ready, which is low whenever something is pending.
    if (apply) begin
      div_d       = pend_div_q;
      cnt_d       = '0;
      state_d     = pend_halt_q ? StHalt : StRun;
      pend_d      = 1'b0;
      cfg_ready_d = 1'b1;
    end
    if (accept) begin
      pend_d      = 1'b1;
      pend_div_d  = cfg_div_clamped;
      pend_halt_d = cfg_halt;
      cfg_ready_d = 1'b0;
    end
  end

  // Outputs: enable from the counter in RUN, from step edges in HALT.
  always_comb begin
    // A step edge that coincides with leaving HALT is dropped.
    step_fire   = (state_q == StHalt) && step_edge && !(apply && !pend_halt_q);
    clken_d     = (state_q == StRun) ? (cnt_q == '0) : step_fire;
    step_done_d = step_fire;
    halted_d    = (state_d == StHalt);
  end

  assign cpu_clken = clken_q;
  assign step_done = step_done_q;
  assign halted    = halted_q;
  assign cfg_ready = cfg_ready_q;
  assign cur_div   = div_q;

endmodule
